// File: rtl/stack_arbiter.sv
// Single-port data stack shared by the PC, ALU and MEM requesters.
// PC has fixed priority; ALU and MEM alternate through a round-robin pointer.
module stack_arbiter #(
    parameter int DATA_LEN  = 8,
    parameter int STK_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 req,
    input  logic [2:0]                 op,
    input  logic [3*DATA_LEN-1:0]      wdata,
    output logic [2:0]                 gnt,
    output logic [2:0]                 done,
    output logic [DATA_LEN-1:0]        rdata,
    output logic                       err,
    output logic [$clog2(STK_DEPTH):0] sp,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(STK_DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(STK_DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [2:0]          gnt_q;
    logic [2:0]          done_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                err_q;
    logic [AW:0]         sp_q;
    logic                rr_q;
    logic                op_q;
    logic [DATA_LEN-1:0] wd_q;

    logic [2:0]          gnt_d;
    logic                op_d;
    logic [DATA_LEN-1:0] wd_d;
    logic [AW:0]         sp_m1;

    logic [DATA_LEN-1:0] mem [STK_DEPTH];

    assign sp_m1 = sp_q - ONE;
    assign full  = (sp_q == DEPTH_V);
    assign empty = (sp_q == '0);
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign sp    = sp_q;

    // rr_q = 1 favours ALU when ALU and MEM request together
    always_comb begin
        gnt_d = 3'b000;
        op_d  = 1'b0;
        wd_d  = '0;
        if (req[0]) begin
            gnt_d = 3'b001;
            op_d  = op[0];
            wd_d  = wdata[0 +: DATA_LEN];
        end else if (req[1] && (rr_q || !req[2])) begin
            gnt_d = 3'b010;
            op_d  = op[1];
            wd_d  = wdata[DATA_LEN +: DATA_LEN];
        end else if (req[2]) begin
            gnt_d = 3'b100;
            op_d  = op[2];
            wd_d  = wdata[2*DATA_LEN +: DATA_LEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            rdata_q <= '0;
            err_q   <= 1'b0;
            sp_q    <= '0;
            rr_q    <= 1'b1;
            op_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q   <= gnt_d;
                        op_q    <= op_d;
                        wd_q    <= wd_d;
                        if (!gnt_d[0]) rr_q <= gnt_d[2];
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    done_q  <= gnt_q;
                    state_q <= RESP;
                    if (op_q) begin
                        if (full) begin
                            err_q <= 1'b1;
                        end else begin
                            sp_q  <= sp_q + ONE;
                            err_q <= 1'b0;
                        end
                    end else if (empty) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        rdata_q <= mem[sp_m1[AW-1:0]];
                        sp_q    <= sp_m1;
                        err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    gnt_q   <= 3'b000;
                    done_q  <= 3'b000;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && op_q && !full)
            mem[sp_q[AW-1:0]] <= wd_q;
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: a queue-based stack model predicts each
// completion; a negedge monitor checks every done pulse against it.
module tb_stack_arbiter;
    localparam int DL    = 8;
    localparam int DEPTH = 16;
    localparam int SPW   = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = '0;
    logic [2:0]      op = '0;
    logic [3*DL-1:0] wdata = '0;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic [DL-1:0]   rdata;
    logic            err;
    logic [SPW-1:0]  sp;
    logic            full;
    logic            empty;

    stack_arbiter #(.DATA_LEN(DL), .STK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .sp(sp),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    g;
        logic [DL-1:0] rd;
        logic          e;
        int            sp;
    } exp_t;

    int errors = 0;
    int checks = 0;

    exp_t          expq[$];
    logic [DL-1:0] stk[$];
    bit            m_rr = 1'b1;
    logic [DL-1:0] m_rdata = '0;
    logic [2:0]    pend = '0;
    logic [2:0]    p_op = '0;
    logic [DL-1:0] pdat[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done !== 3'b000) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=%b with no pending expectation", done);
            end else begin
                e = expq.pop_front();
                check("done", done, e.g);
                check("gnt_resp", gnt, e.g);
                check("rdata", rdata, e.rd);
                check("err", err, e.e);
                check("sp", sp, e.sp);
                check("full", full, e.sp == DEPTH);
                check("empty", empty, e.sp == 0);
            end
        end
    end

    task automatic drive_pending();
        req = pend;
        op  = p_op;
        for (int i = 0; i < 3; i++) wdata[i*DL +: DL] = pdat[i];
    endtask

    task automatic model_reset();
        pend = '0;
        req  = '0;
        stk.delete();
        expq.delete();
        m_rr    = 1'b1;
        m_rdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_sp"}, sp, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_empty"}, empty, 1);
    endtask

    // Asynchronous reset applied between clock edges
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One arbitration round: add new requesters, predict winner and result, run it
    task automatic do_round(input logic [2:0] nreq, input logic [2:0] nop, input logic [3*DL-1:0] nd);
        int   w;
        int   cyc;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (nreq[i] && !pend[i]) begin
                pend[i] = 1'b1;
                p_op[i] = nop[i];
                pdat[i] = nd[i*DL +: DL];
            end
        end
        drive_pending();
        if (pend == 3'b000) return;

        if (pend[0])                 w = 0;
        else if (pend[1] && pend[2]) w = m_rr ? 1 : 2;
        else                         w = pend[1] ? 1 : 2;
        if (w != 0) m_rr = (w == 1) ? 1'b0 : 1'b1;

        if (p_op[w]) begin
            if (stk.size() == DEPTH) e.e = 1'b1;
            else begin
                stk.push_back(pdat[w]);
                e.e = 1'b0;
            end
        end else begin
            if (stk.size() == 0) begin
                m_rdata = '0;
                e.e = 1'b1;
            end else begin
                m_rdata = stk.pop_back();
                e.e = 1'b0;
            end
        end
        e.g  = 3'(1 << w);
        e.rd = m_rdata;
        e.sp = stk.size();
        expq.push_back(e);

        @(posedge clk);
        @(negedge clk);
        check("gnt_access", gnt, e.g);
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (done === 3'b000 && cyc < 8);
        check("latency", cyc, 2);
        pend[w] = 1'b0;
        req[w]  = 1'b0;
    endtask

    task automatic abort_in_access(input logic [2:0] nreq, input logic [2:0] nop);
        @(negedge clk);
        pend = nreq;
        p_op = nop;
        drive_pending();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_gnt", gnt, 0);
        check("abort_done", done, 0);
        check("abort_sp", sp, 0);
        check("abort_empty", empty, 1);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("abort_done_in_rst", done, 0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_sp_after", sp, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]      nreq;
        logic [2:0]      nop;
        logic [3*DL-1:0] nd;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // ALU push 0x11, 0x22, then two pops
        do_round(3'b010, 3'b010, {8'h00, 8'h11, 8'h00});
        do_round(3'b010, 3'b010, {8'h00, 8'h22, 8'h00});
        do_round(3'b010, 3'b000, '0);
        do_round(3'b010, 3'b000, '0);

        // Mid-run reset, then PC vs ALU pop with stack 0x05, 0x09
        do_round(3'b010, 3'b010, {8'h00, 8'h33, 8'h00});
        do_reset();
        do_round(3'b010, 3'b010, {8'h00, 8'h05, 8'h00});
        do_round(3'b010, 3'b010, {8'h00, 8'h09, 8'h00});
        do_round(3'b011, 3'b000, '0);
        do_round(3'b100, 3'b100, {8'h77, 8'h00, 8'h00});
        do_round(3'b000, 3'b000, '0);

        // ALU and MEM both requesting every round from reset
        do_reset();
        for (int i = 0; i < 6; i++)
            do_round(3'b110, 3'b110, {8'(8'hA0 + i), 8'(8'hB0 + i), 8'h00});

        // Fill to the top, overflow, confirm the top entry survived
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_round(3'b010, 3'b010, {8'h00, 8'(8'h40 + i), 8'h00});
        do_round(3'b100, 3'b100, {8'hEE, 8'h00, 8'h00});
        do_round(3'b001, 3'b000, '0);

        // Underflow, then reset during ACCESS
        do_reset();
        do_round(3'b010, 3'b000, '0);
        do_round(3'b100, 3'b100, {8'h5A, 8'h00, 8'h00});
        abort_in_access(3'b010, 3'b000);
        do_round(3'b100, 3'b100, {8'h6B, 8'h00, 8'h00});
        do_round(3'b010, 3'b000, '0);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            nreq[0] = ($urandom_range(0, 5) == 0);
            nreq[1] = 1'($urandom_range(0, 1));
            nreq[2] = 1'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) nop[j] = ($urandom_range(0, 9) < 6);
            nd = 24'($urandom);
            do_round(nreq, nop, nd);
        end
        while (pend != 3'b000) do_round(3'b000, 3'b000, '0);

        repeat (4) @(negedge clk);
        check("scoreboard_drain", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Single-port data-stack controller for the AZ10 stack CPU. It owns the stack storage and stack pointer and shares them between three requesters: the program counter (branch-target pops), the ALU (operand pops, result pushes) and the memory unit (load pushes, store pops). It serialises all accesses through a req/gnt/done handshake. It uses fixed priority for the PC and round-robin between the ALU and the memory unit. It reports full, empty and overflow/underflow errors.

## Interface
- DATA_LEN, 8, stack word width
- STK_DEPTH, 16, number of stack entries; power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  access request per requester; bit 0 = PC, bit 1 = ALU, bit 2 = MEM
- op  in  3  per-requester operation, 1 = push, 0 = pop; sampled with req
- wdata  in  3*DATA_LEN  per-requester push data; slice i = bits [i*DATA_LEN +: DATA_LEN]
- gnt  out  3  one-hot grant, high for the granted requester during ACCESS and RESP
- done  out  3  one-hot, one-cycle completion pulse
- rdata  out  DATA_LEN  popped word; valid while done is high; held until the next pop
- err  out  1  high with done when the operation overflowed or underflowed
- sp  out  $clog2(STK_DEPTH)+1  current entry count, 0..STK_DEPTH
- full  out  1  sp == STK_DEPTH (combinational from sp)
- empty  out  1  sp == 0 (combinational from sp)

## Operation
- Storage: internal array mem[0..STK_DEPTH-1] of DATA_LEN bits, not reset. Push writes mem[sp] and then sp+1. Pop reads mem[sp-1] and then sp-1.
- FSM states:
  - IDLE: sample req. If any bit is set, latch the winner index, its op and its wdata slice, set gnt[winner], go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: perform the latched operation, assert done[winner], update err, go to RESP.
  - RESP: done is high this cycle. At the end of the cycle clear gnt and done, go to IDLE. req is not sampled in RESP.
- Arbitration:
  - PC (bit 0) always wins when asserted.
  - Otherwise the round-robin pointer rr decides between ALU and MEM. rr = 1 favours ALU, rr = 0 favours MEM.
  - When only one of ALU/MEM requests, it wins regardless of rr.
  - rr flips to favour the other one only when ALU or MEM was granted. A PC grant leaves rr unchanged.
- Error handling:
  - Push with full = 1: no write, sp unchanged, err = 1.
  - Pop with empty = 1: rdata = 0, sp unchanged, err = 1.
  - Successful operation: err = 0.
- Requester rules:
  - Hold req, op and wdata stable from assertion until done is seen.
  - Deassert req on the clock edge that ends the done cycle.
  - A requester that keeps req high is re-arbitrated like any other requester.
- Widths: sp arithmetic is unsigned, $clog2(STK_DEPTH)+1 bits, never wraps; the boundary checks prevent it.

## Timing
- Reset (async, any state): state = IDLE, gnt = 0, done = 0, err = 0, rdata = 0, sp = 0, rr = 1 (favour ALU). full = 0, empty = 1. Stack contents are undefined.
- Reset asserted mid-ACCESS or mid-RESP aborts the operation. No done is produced. sp returns to 0.
- Latency, with req high before edge E0 in IDLE:
  - E0: gnt rises.
  - E1: done, rdata, err and the new sp become visible.
  - E2: gnt and done fall, state returns to IDLE.
  - E3: earliest next sample.
- Throughput: one operation per 3 cycles.
- Simultaneous requests: exactly one grant per IDLE sample. Losers stay pending and are not acknowledged.
- The PC can starve ALU/MEM only if it requests every IDLE cycle. This is by design, because branches are rare.

## Test plan
- Reset check: assert rst mid-run → all outputs at their reset values and empty = 1 asynchronously, before the next clk edge.
- ALU pushes 0x11, 0x22, then pops twice → rdata 0x22 then 0x11, err = 0, sp sequence 1, 2, 1, 0, done 2 cycles after each IDLE sample.
- PC and ALU request pops in the same cycle with stack holding 0x05 and 0x09 (top) → PC gets 0x09 first, ALU gets 0x05 on the next transaction, and rr is unchanged by the PC grant.
- ALU and MEM hold req continuously after reset (rr = 1), each doing pushes → grants alternate ALU, MEM, ALU, MEM.
- 16 pushes then a 17th push (STK_DEPTH = 16) → 17th push: err = 1, full = 1, sp stays 16, mem[15] unchanged.
- Pop on an empty stack → rdata = 0, err = 1, sp = 0. Then assert rst during the next ACCESS → no done, sp = 0.
